// File: rtl/pcileech_tlps128_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pcileech_tlps128_tx_arbiter
//
// Packet-atomic arbiter sharing the 128-bit completion/TX TLP path toward the
// PCIe core between NUM_SRC sources (source 0 = config-space completions).
// One source owns the path for a whole TLP; selection is round-robin with an
// optional bounded strict priority for source 0. A watchdog releases a grant
// whose owner stops presenting data mid-packet.
//
// Ports:
//   clk_pcie, rst     clock, synchronous active-high reset
//   src_tdata         128-bit beat per source, source i at [128*i +: 128]
//   src_tkeepdw       4-bit DW-valid mask per source
//   src_tlast         last beat of TLP per source
//   src_has_data      beat valid / request per source
//   src_tready        beat accepted from source i
//   tx_tdata/tx_tkeepdw/tx_tlast/tx_has_data   muxed beat toward the core
//   tx_tready         core accepts beat
//   grant             one-hot current owner, 0 when idle
//   pkt_count         TLPs completed (wrapping)
//   err_stall         sticky: a grant was released by the stall watchdog
//   dbg_state         FSM state (0 = IDLE, 1 = XFER)
//
// Handshake: a beat moves from source g to the core on a cycle where
// tx_has_data (= src_has_data[g] in XFER) and tx_tready are both high;
// src_tready[g] mirrors tx_tready combinationally, so the source and the
// core see the same transfer in the same cycle.
// ---------------------------------------------------------------------------
module pcileech_tlps128_tx_arbiter #(
   parameter int NUM_SRC   = 3,
   parameter int PRIO0_EN  = 1,
   parameter int PRIO0_MAX = 4,
   parameter int STALL_MAX = 255
) (
   input  logic                     clk_pcie,
   input  logic                     rst,
   input  logic [128*NUM_SRC-1:0]   src_tdata,
   input  logic [4*NUM_SRC-1:0]     src_tkeepdw,
   input  logic [NUM_SRC-1:0]       src_tlast,
   input  logic [NUM_SRC-1:0]       src_has_data,
   output logic [NUM_SRC-1:0]       src_tready,
   output logic [127:0]             tx_tdata,
   output logic [3:0]               tx_tkeepdw,
   output logic                     tx_tlast,
   output logic                     tx_has_data,
   input  logic                     tx_tready,
   output logic [NUM_SRC-1:0]       grant,
   output logic [31:0]              pkt_count,
   output logic                     err_stall,
   output logic                     dbg_state
);

   localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_XFER = 1'b1} state_t;

   state_t          state;
   logic [IW-1:0]   gidx;
   logic [IW-1:0]   last_grant;
   logic [3:0]      prio_cnt;
   logic [15:0]     stall_cnt;

   logic            in_xfer;
   logic            cur_has;
   logic            beat;
   logic [16:0]     stall_nxt;

   logic [NUM_SRC-1:0] req_m;
   logic            others_req;
   logic            excl0;
   logic [IW-1:0]   win_idx;
   logic            win_found;
   int              idx;

   assign dbg_state = state;

   // ---------------- arbitration ----------------
   always_comb begin
      others_req = |src_has_data[NUM_SRC-1:1];
      // Source 0 has used up its priority budget while someone else waits.
      excl0      = (PRIO0_EN != 0) && others_req && (prio_cnt >= 4'(PRIO0_MAX));
      req_m      = src_has_data;
      if (excl0) req_m[0] = 1'b0;
      win_idx    = '0;
      win_found  = 1'b0;
      idx        = 0;
      if ((PRIO0_EN != 0) && req_m[0]) begin
         win_found = 1'b1;
      end else begin
         for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last_grant) + k) % NUM_SRC;
            if (!win_found && req_m[idx]) begin
               win_idx   = IW'(idx);
               win_found = 1'b1;
            end
         end
      end
   end

   // ---------------- datapath ----------------
   assign in_xfer     = (state == S_XFER);
   assign cur_has     = src_has_data[gidx];
   assign tx_has_data = in_xfer & cur_has;
   assign beat        = tx_has_data & tx_tready;
   assign stall_nxt   = {1'b0, stall_cnt} + 17'd1;

   always_comb begin
      tx_tdata   = '0;
      tx_tkeepdw = '0;
      tx_tlast   = 1'b0;
      if (in_xfer) begin
         tx_tdata   = src_tdata[128*gidx +: 128];
         tx_tkeepdw = src_tkeepdw[4*gidx +: 4];
         tx_tlast   = src_tlast[gidx];
      end
   end

   // rst gates tready so a packet cut by reset never reports an acceptance.
   always_comb begin
      src_tready = '0;
      if (in_xfer && !rst) src_tready[gidx] = tx_tready;
   end

   // ---------------- FSM ----------------
   always_ff @(posedge clk_pcie) begin
      if (rst) begin
         state      <= S_IDLE;
         grant      <= '0;
         gidx       <= '0;
         last_grant <= IW'(NUM_SRC - 1);
         prio_cnt   <= '0;
         stall_cnt  <= '0;
         pkt_count  <= '0;
         err_stall  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (win_found) begin
                  state     <= S_XFER;
                  grant     <= NUM_SRC'(1) << win_idx;
                  gidx      <= win_idx;
                  stall_cnt <= '0;
                  if (PRIO0_EN != 0) begin
                     if (win_idx == '0) begin
                        // Lone requester 0 is served without charging the budget.
                        if (others_req && prio_cnt != 4'hF) prio_cnt <= prio_cnt + 4'd1;
                     end else begin
                        prio_cnt <= '0;
                     end
                  end
               end
            end
            S_XFER: begin
               if (beat) begin
                  stall_cnt <= '0;
                  if (tx_tlast) begin
                     state      <= S_IDLE;
                     grant      <= '0;
                     last_grant <= gidx;
                     pkt_count  <= pkt_count + 32'd1;
                  end
               end else if (!cur_has) begin
                  // Only an absent owner counts; core back-pressure never does.
                  if (stall_nxt >= 17'(STALL_MAX)) begin
                     state      <= S_IDLE;
                     grant      <= '0;
                     last_grant <= gidx;
                     err_stall  <= 1'b1;
                     stall_cnt  <= '0;
                  end else begin
                     stall_cnt  <= stall_nxt[15:0];
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcileech_tlps128_tx_arbiter.sv
// Directed bench: a priority-enabled instance (u_dut) and a pure round-robin
// instance (u_rr) share the same source/core stimulus.
module tb_pcileech_tlps128_tx_arbiter;

   logic           clk_pcie = 1'b0;
   logic           rst      = 1'b1;
   logic [383:0]   src_tdata    = '0;
   logic [11:0]    src_tkeepdw  = '0;
   logic [2:0]     src_tlast    = '0;
   logic [2:0]     src_has_data = '0;
   logic           tx_tready    = 1'b0;

   logic [2:0]     p_src_tready, r_src_tready;
   logic [127:0]   p_tx_tdata, r_tx_tdata;
   logic [3:0]     p_tx_tkeepdw, r_tx_tkeepdw;
   logic           p_tx_tlast, r_tx_tlast;
   logic           p_tx_has_data, r_tx_has_data;
   logic [2:0]     p_grant, r_grant;
   logic [31:0]    p_pkt_count, r_pkt_count;
   logic           p_err_stall, r_err_stall;
   logic           p_dbg_state, r_dbg_state;

   int tests = 0;
   int fails = 0;

   localparam logic [127:0] D_S0_B0 = 128'h0000_0000_AAAA_0000_0000_0000_0000_0010;
   localparam logic [127:0] D_S0_B1 = 128'h0000_0000_AAAA_0000_0000_0000_0000_0011;
   localparam logic [127:0] D_S1_B0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] D_S1_B1 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
   localparam logic [127:0] D_S1_B2 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEED_F00D;
   localparam logic [127:0] D_S2_B0 = 128'h2222_0000_0000_0000_0000_0000_0000_2222;

   always #5 clk_pcie = ~clk_pcie;

   pcileech_tlps128_tx_arbiter #(.NUM_SRC(3), .PRIO0_EN(1), .PRIO0_MAX(4), .STALL_MAX(255)) u_dut (
      .clk_pcie(clk_pcie), .rst(rst),
      .src_tdata(src_tdata), .src_tkeepdw(src_tkeepdw), .src_tlast(src_tlast),
      .src_has_data(src_has_data), .src_tready(p_src_tready),
      .tx_tdata(p_tx_tdata), .tx_tkeepdw(p_tx_tkeepdw), .tx_tlast(p_tx_tlast),
      .tx_has_data(p_tx_has_data), .tx_tready(tx_tready),
      .grant(p_grant), .pkt_count(p_pkt_count), .err_stall(p_err_stall), .dbg_state(p_dbg_state)
   );

   pcileech_tlps128_tx_arbiter #(.NUM_SRC(3), .PRIO0_EN(0), .PRIO0_MAX(4), .STALL_MAX(255)) u_rr (
      .clk_pcie(clk_pcie), .rst(rst),
      .src_tdata(src_tdata), .src_tkeepdw(src_tkeepdw), .src_tlast(src_tlast),
      .src_has_data(src_has_data), .src_tready(r_src_tready),
      .tx_tdata(r_tx_tdata), .tx_tkeepdw(r_tx_tkeepdw), .tx_tlast(r_tx_tlast),
      .tx_has_data(r_tx_has_data), .tx_tready(tx_tready),
      .grant(r_grant), .pkt_count(r_pkt_count), .err_stall(r_err_stall), .dbg_state(r_dbg_state)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_src(input int i, input logic [127:0] d, input logic [3:0] k,
                          input logic l, input logic h);
      src_tdata[128*i +: 128] = d;
      src_tkeepdw[4*i +: 4]   = k;
      src_tlast[i]            = l;
      src_has_data[i]         = h;
   endtask

   task automatic next_cycle();
      @(posedge clk_pcie);
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      src_has_data = '0;
      src_tlast    = '0;
      src_tdata    = '0;
      src_tkeepdw  = '0;
      next_cycle();
      rst          = 1'b0;
   endtask

   initial begin
      logic [2:0] exp_g;

      // ---- reset values ----
      rst = 1'b1;
      repeat (3) next_cycle();
      rst = 1'b0;
      @(negedge clk_pcie);
      chk("rst_grant",     128'(p_grant), 128'(0));
      chk("rst_pkt",       128'(p_pkt_count), 128'(0));
      chk("rst_err",       128'(p_err_stall), 128'(0));
      chk("rst_txhas",     128'(p_tx_has_data), 128'(0));
      chk("rst_tready",    128'(p_src_tready), 128'(0));
      chk("rst_tdata",     p_tx_tdata, 128'(0));
      chk("rst_state",     128'(p_dbg_state), 128'(0));
      next_cycle();

      // ---- single source 1, 3-beat TLP ----
      do_reset();
      tx_tready = 1'b1;
      set_src(1, D_S1_B0, 4'hF, 1'b0, 1'b1);
      @(negedge clk_pcie);
      chk("s1_idle_grant",  128'(p_grant), 128'(0));
      chk("s1_idle_tready", 128'(p_src_tready), 128'(0));
      chk("s1_idle_txhas",  128'(p_tx_has_data), 128'(0));
      next_cycle();
      @(negedge clk_pcie);
      chk("s1_grant",   128'(p_grant), 128'(3'b010));
      chk("s1_txhas",   128'(p_tx_has_data), 128'(1));
      chk("s1_tready",  128'(p_src_tready), 128'(3'b010));
      chk("s1_b0",      p_tx_tdata, D_S1_B0);
      chk("s1_b0_last", 128'(p_tx_tlast), 128'(0));
      next_cycle();
      set_src(1, D_S1_B1, 4'hF, 1'b0, 1'b1);
      @(negedge clk_pcie);
      chk("s1_b1", p_tx_tdata, D_S1_B1);
      next_cycle();
      set_src(1, D_S1_B2, 4'h3, 1'b1, 1'b1);
      @(negedge clk_pcie);
      chk("s1_b2",      p_tx_tdata, D_S1_B2);
      chk("s1_b2_last", 128'(p_tx_tlast), 128'(1));
      chk("s1_b2_keep", 128'(p_tx_tkeepdw), 128'(4'h3));
      next_cycle();
      set_src(1, '0, 4'h0, 1'b0, 1'b0);
      @(negedge clk_pcie);
      chk("s1_end_grant", 128'(p_grant), 128'(0));
      chk("s1_end_pkt",   128'(p_pkt_count), 128'(1));
      chk("s1_end_txhas", 128'(p_tx_has_data), 128'(0));
      chk("s1_end_tdata", p_tx_tdata, 128'(0));
      next_cycle();

      // ---- round robin (u_rr), all three sources, 1-beat TLPs ----
      do_reset();
      tx_tready = 1'b1;
      set_src(0, D_S0_B0, 4'hF, 1'b1, 1'b1);
      set_src(1, D_S1_B0, 4'hF, 1'b1, 1'b1);
      set_src(2, D_S2_B0, 4'hF, 1'b1, 1'b1);
      for (int n = 0; n < 12; n++) begin
         @(negedge clk_pcie);
         // even slots are the mandatory IDLE cycles; odd slots go 0,1,2,0,1,2
         exp_g = (n % 2 == 0) ? 3'b000 : (3'b001 << ((n / 2) % 3));
         chk("rr_grant", 128'(r_grant), 128'(exp_g));
         if (n % 2 == 1)
            chk("rr_tdata", r_tx_tdata,
                ((n / 2) % 3 == 0) ? D_S0_B0 : ((n / 2) % 3 == 1) ? D_S1_B0 : D_S2_B0);
         next_cycle();
      end
      chk("rr_pkt", 128'(r_pkt_count), 128'(6));

      // ---- bounded priority (u_dut), sources 0 and 2 ----
      do_reset();
      tx_tready = 1'b1;
      set_src(0, D_S0_B0, 4'hF, 1'b1, 1'b1);
      set_src(1, '0, 4'h0, 1'b0, 1'b0);
      set_src(2, D_S2_B0, 4'hF, 1'b1, 1'b1);
      for (int n = 0; n < 20; n++) begin
         @(negedge clk_pcie);
         // expected order 0,0,0,0,2,0,0,0,0,2
         exp_g = (n % 2 == 0) ? 3'b000 : (((n / 2) % 5 == 4) ? 3'b100 : 3'b001);
         chk("prio_grant", 128'(p_grant), 128'(exp_g));
         next_cycle();
      end

      // ---- core back-pressure for 300 cycles never trips the watchdog ----
      do_reset();
      tx_tready = 1'b0;
      set_src(0, '0, 4'h0, 1'b0, 1'b0);
      set_src(2, '0, 4'h0, 1'b0, 1'b0);
      set_src(1, D_S1_B0, 4'hF, 1'b0, 1'b1);
      next_cycle();
      repeat (300) next_cycle();
      @(negedge clk_pcie);
      chk("bp_grant",  128'(p_grant), 128'(3'b010));
      chk("bp_err",    128'(p_err_stall), 128'(0));
      chk("bp_txhas",  128'(p_tx_has_data), 128'(1));
      chk("bp_tready", 128'(p_src_tready), 128'(0));
      next_cycle();
      tx_tready = 1'b1;
      set_src(1, D_S1_B1, 4'hF, 1'b1, 1'b1);
      @(negedge clk_pcie);
      chk("bp_tready_on", 128'(p_src_tready), 128'(3'b010));
      next_cycle();
      set_src(1, '0, 4'h0, 1'b0, 1'b0);
      @(negedge clk_pcie);
      chk("bp_pkt",       128'(p_pkt_count), 128'(1));
      chk("bp_end_grant", 128'(p_grant), 128'(0));
      next_cycle();

      // ---- owner stalls: watchdog release after 255 idle cycles ----
      do_reset();
      tx_tready = 1'b1;
      set_src(1, D_S1_B0, 4'hF, 1'b0, 1'b1);
      next_cycle();                      // grant edge
      @(negedge clk_pcie);
      chk("st_grant", 128'(p_grant), 128'(3'b010));
      next_cycle();                      // beat 1 transferred
      set_src(1, '0, 4'h0, 1'b0, 1'b0);
      @(negedge clk_pcie);
      chk("st_txhas", 128'(p_tx_has_data), 128'(0));
      repeat (254) @(posedge clk_pcie);  // 254 idle cycles counted
      @(negedge clk_pcie);
      chk("st_hold_grant", 128'(p_grant), 128'(3'b010));
      chk("st_hold_err",   128'(p_err_stall), 128'(0));
      next_cycle();                      // 255th idle cycle
      @(negedge clk_pcie);
      chk("st_rel_grant", 128'(p_grant), 128'(0));
      chk("st_rel_err",   128'(p_err_stall), 128'(1));
      chk("st_rel_pkt",   128'(p_pkt_count), 128'(0));
      next_cycle();
      set_src(1, D_S1_B0, 4'hF, 1'b1, 1'b1);
      set_src(2, D_S2_B0, 4'hF, 1'b1, 1'b1);
      next_cycle();
      @(negedge clk_pcie);
      chk("st_next_grant", 128'(p_grant), 128'(3'b100));
      chk("st_next_tdata", p_tx_tdata, D_S2_B0);
      next_cycle();
      set_src(1, '0, 4'h0, 1'b0, 1'b0);
      set_src(2, '0, 4'h0, 1'b0, 1'b0);
      set_src(0, D_S0_B0, 4'hF, 1'b0, 1'b1);
      @(negedge clk_pcie);
      chk("st_next_pkt", 128'(p_pkt_count), 128'(1));

      // ---- reset during beat 2 of a 4-beat TLP from source 0 ----
      next_cycle();
      @(negedge clk_pcie);
      chk("mr_grant", 128'(p_grant), 128'(3'b001));
      chk("mr_b0",    p_tx_tdata, D_S0_B0);
      next_cycle();
      set_src(0, D_S0_B1, 4'hF, 1'b0, 1'b1);
      rst = 1'b1;
      @(negedge clk_pcie);
      chk("mr_tready_gated", 128'(p_src_tready), 128'(0));
      next_cycle();
      rst = 1'b0;
      set_src(0, D_S0_B0, 4'hF, 1'b1, 1'b1);
      set_src(1, D_S1_B0, 4'hF, 1'b1, 1'b1);
      set_src(2, D_S2_B0, 4'hF, 1'b1, 1'b1);
      @(negedge clk_pcie);
      chk("mr_rst_grant", 128'(p_grant), 128'(0));
      chk("mr_rst_txhas", 128'(p_tx_has_data), 128'(0));
      chk("mr_rst_tdata", p_tx_tdata, 128'(0));
      chk("mr_rst_tlast", 128'(p_tx_tlast), 128'(0));
      chk("mr_rst_pkt",   128'(p_pkt_count), 128'(0));
      chk("mr_rst_err",   128'(p_err_stall), 128'(0));
      chk("mr_rst_state", 128'(p_dbg_state), 128'(0));
      next_cycle();
      @(negedge clk_pcie);
      chk("mr_post_grant",    128'(p_grant), 128'(3'b001));
      chk("mr_post_rr_grant", 128'(r_grant), 128'(3'b001));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pcileech_tlps128_tx_arbiter.md
# pcileech_tlps128_tx_arbiter

Packet-atomic arbiter that shares the single 128-bit completion/TX TLP path toward the PCIe core between NUM_SRC TLP sources: config-space shadow completions, BAR read completions and the host-DMA path. It sits between the per-source completion FIFOs and the core TX interface. It grants one source per whole TLP using round-robin with optional bounded priority for source 0 (config completions). It also provides stall detection, a grant indicator and a packet counter for the debug path.

## Interface
Parameters:
- NUM_SRC, 3: number of sources (2..8); source 0 = config-space completions.
- PRIO0_EN, 1: 1 = source 0 gets bounded strict priority.
- PRIO0_MAX, 4: max consecutive priority grants to source 0 while others wait (1..15).
- STALL_MAX, 255: idle cycles mid-packet before the grant is forcibly released (1..65535).

Ports:
- clk_pcie  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- src_tdata  in  128*NUM_SRC  TLP beat per source; source i at [128*i+:128].
- src_tkeepdw  in  4*NUM_SRC  DW-valid mask per source.
- src_tlast  in  NUM_SRC  last beat of TLP.
- src_has_data  in  NUM_SRC  beat valid (request).
- src_tready  out  NUM_SRC  beat accepted from source i.
- tx_tdata  out  128  muxed beat.
- tx_tkeepdw  out  4  muxed mask.
- tx_tlast  out  1  muxed last.
- tx_has_data  out  1  beat valid toward core.
- tx_tready  in  1  core accepts beat.
- grant  out  NUM_SRC  one-hot current owner; 0 when idle.
- pkt_count  out  32  total TLPs completed, wraps 0xFFFFFFFF→0.
- err_stall  out  1  sticky: a grant was released by the stall watchdog.

## Operation
- States: IDLE, XFER.
- IDLE: if any src_has_data[i], select a winner, load grant, and go to XFER on the next edge. No src_tready asserted in IDLE.
- Selection, round-robin: scan from (last_grant+1) mod NUM_SRC upward and pick the first requester. last_grant resets to NUM_SRC-1, so source 0 scans first after reset.
- Priority, when PRIO0_EN=1: source 0 wins whenever it requests and prio_cnt < PRIO0_MAX.
  - prio_cnt (4-bit) increments on each grant to source 0 while any other source requests.
  - prio_cnt clears when any other source is granted.
  - At prio_cnt == PRIO0_MAX with another source requesting, source 0 is excluded from that arbitration.
  - If source 0 is the only requester, it is granted regardless and prio_cnt holds.
- XFER, datapath:
  - tx_tdata/tx_tkeepdw/tx_tlast = granted source's signals (combinational mux).
  - tx_has_data = src_has_data[g].
  - src_tready[g] = tx_tready; all other src_tready = 0.
- XFER, end of packet: a beat transfers when tx_has_data & tx_tready. A transfer with tx_tlast=1 returns to IDLE, sets last_grant=g, clears grant, and increments pkt_count.
- Outside XFER: tx_has_data=0 and tx_tdata/tx_tkeepdw/tx_tlast are driven 0.
- Stall watchdog: stall_cnt (16-bit) clears on every beat transfer and on entering XFER. It increments in XFER each cycle src_has_data[g]=0.
  - When stall_cnt reaches STALL_MAX: release grant, go to IDLE, set last_grant=g, set err_stall. pkt_count is not incremented.
  - tx_has_data=0 throughout the stall; the core sees a truncated TLP.
  - Stalls caused by tx_tready=0 while data is valid never count.
- err_stall clears only on rst.

## Timing
- Reset, on the first edge with rst=1:
  - state=IDLE, grant=0, src_tready=0, tx_has_data=0, tx_tdata/tx_tkeepdw/tx_tlast=0.
  - pkt_count=0, err_stall=0, prio_cnt=0, stall_cnt=0, last_grant=NUM_SRC-1.
- rst mid-packet: drop the transfer immediately and assert no src_tready on that cycle. Sources own their own flush.
- Arbitration latency: request seen in IDLE at cycle N, grant and tx_has_data visible at N+1.
- Throughput: one beat per cycle within a packet. One mandatory IDLE cycle between packets, so back-to-back single-beat TLPs run at 50%.
- Request changes: requests arriving while in XFER never preempt. A source dropping has_data in IDLE before the grant edge is harmless; its grant then idles under the watchdog.
- src_tready is combinational from tx_tready. No registered stage, so zero added data latency.

## Test plan
- Single source 1, 3-beat TLP, tx_tready=1 → grant=0b010 one cycle after request, 3 consecutive beats bit-exact, tlast on beat 3, pkt_count=1, grant=0 next cycle.
- All three sources requesting continuously with 1-beat TLPs, PRIO0_EN=0 → grant order 0,1,2,0,1,2; one IDLE cycle between each.
- PRIO0_EN=1, PRIO0_MAX=4, sources 0 and 2 continuously requesting → order 0,0,0,0,2,0,0,0,0,2; prio_cnt clears after each source-2 grant.
- Source 1 mid-packet with tx_tready held 0 for 300 cycles (STALL_MAX=255) → no release, err_stall=0, packet completes on tready.
- Source 1 drops has_data after beat 1 for 255 cycles → grant released on that cycle, err_stall=1, pkt_count unchanged, next arbitration starts at source 2.
- Reset asserted during beat 2 of a 4-beat TLP → next cycle all outputs at reset values. Post-reset arbitration grants source 0 first.
